// File: rtl/sel_debounce_toggle_if.sv
// Button / auto-scan control and select outputs of the mux select generator.
interface sel_debounce_toggle_if;
  logic btn_in;
  logic auto_en;
  logic btn_level;
  logic btn_pulse;
  logic sel_out;

  // Driver side: supplies the raw button and auto-scan enable
  modport master (
    output btn_in,
    output auto_en,
    input  btn_level,
    input  btn_pulse,
    input  sel_out
  );

  // Select generator side
  modport slave (
    input  btn_in,
    input  auto_en,
    output btn_level,
    output btn_pulse,
    output sel_out
  );
endinterface

// File: rtl/sel_debounce_toggle.sv
// Select generator for the 2:1 mux stage: synchronises and debounces a raw
// push-button, toggles a select register on each press, and optionally
// toggles it periodically in auto-scan mode.
module sel_debounce_toggle #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned AUTO_PERIOD     = 100000000
) (
  input  logic                  clk,
  input  logic                  rst,
  sel_debounce_toggle_if.slave  bus
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned AP_W = $clog2(AUTO_PERIOD);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [AP_W-1:0] AP_LAST = AP_W'(AUTO_PERIOD - 1);
  localparam logic [AP_W-1:0] AP_ONE  = AP_W'(1);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } db_state_e;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_q;

  db_state_e              state_q, state_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;

  logic [AP_W-1:0]        auto_cnt_q, auto_cnt_d;
  logic                   auto_req_q, auto_req_d;

  logic                   sel_q;

  // Input synchroniser for the asynchronous button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.btn_in};
    end
  end

  assign sync_q = sync_r[SYNC_STAGES-1];

  // Debounce FSM state, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE_LOW;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
    end
  end

  // Debounce next-state: a new level is accepted only after DEBOUNCE_CYCLES
  // consecutive agreeing samples; only the press (rising) edge pulses
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    pulse_d  = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        db_cnt_d = '0;
        if (sync_q) begin
          state_d  = WAIT_HIGH;
          db_cnt_d = DB_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!sync_q) begin
          state_d  = IDLE_LOW;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = IDLE_HIGH;
          db_cnt_d = '0;
          level_d  = 1'b1;
          pulse_d  = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      IDLE_HIGH: begin
        db_cnt_d = '0;
        if (!sync_q) begin
          state_d  = WAIT_LOW;
          db_cnt_d = DB_ONE;
        end
      end
      WAIT_LOW: begin
        if (sync_q) begin
          state_d  = IDLE_HIGH;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = IDLE_LOW;
          db_cnt_d = '0;
          level_d  = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      default: begin
        state_d  = IDLE_LOW;
        db_cnt_d = '0;
      end
    endcase
  end

  // Auto-scan next-state; a press restarts the period on the same edge the
  // pulse is raised so the next auto toggle lands a full period after the
  // button-driven flip
  always_comb begin
    auto_cnt_d = auto_cnt_q;
    auto_req_d = 1'b0;
    if (!bus.auto_en) begin
      auto_cnt_d = '0;
    end else if (auto_cnt_q == AP_LAST) begin
      auto_cnt_d = '0;
      auto_req_d = 1'b1;
    end else begin
      auto_cnt_d = auto_cnt_q + AP_ONE;
    end
    if (pulse_d) begin
      auto_cnt_d = '0;
    end
  end

  // Auto-scan counter and pending toggle request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_cnt_q <= '0;
      auto_req_q <= 1'b0;
    end else begin
      auto_cnt_q <= auto_cnt_d;
      auto_req_q <= auto_req_d;
    end
  end

  // Select register: coincident button and auto requests flip it only once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= 1'b0;
    end else if (pulse_q || auto_req_q) begin
      sel_q <= ~sel_q;
    end
  end

  assign bus.btn_level = level_q;
  assign bus.btn_pulse = pulse_q;
  assign bus.sel_out   = sel_q;

endmodule

// File: tb/tb_sel_debounce_toggle.sv
// Directed, table-driven bench for sel_debounce_toggle (small parameters).
module tb_sel_debounce_toggle;

  logic clk;
  logic rst;

  sel_debounce_toggle_if bus ();

  sel_debounce_toggle #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .AUTO_PERIOD    (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic  rst;
    logic  btn;
    logic  auto_en;
    logic  exp_level;
    logic  exp_pulse;
    logic  exp_sel;
    string tag;
  } vec_t;

  vec_t vecs[$];
  int   vectors;
  int   miscompares;

  // Posedges at 10, 20, 30 ... ns
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  function automatic void add(input int n, input logic r, input logic b,
                              input logic a, input logic l, input logic p,
                              input logic s, input string tag);
    vec_t v;
    v.rst = r; v.btn = b; v.auto_en = a;
    v.exp_level = l; v.exp_pulse = p; v.exp_sel = s; v.tag = tag;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic check(input logic l, input logic p, input logic s,
                       input string tag, input int row);
    vectors++;
    if ({bus.btn_level, bus.btn_pulse, bus.sel_out} !== {l, p, s}) begin
      miscompares++;
      $display("FAIL %s row %0d @%0t: got level=%b pulse=%b sel=%b, want level=%b pulse=%b sel=%b",
               tag, row, $time, bus.btn_level, bus.btn_pulse, bus.sel_out, l, p, s);
    end
  endtask

  task automatic step(input logic r, input logic b, input logic a,
                      input logic l, input logic p, input logic s,
                      input string tag, input int row);
    rst = r;
    bus.btn_in = b;
    bus.auto_en = a;
    @(posedge clk);
    #1;
    check(l, p, s, tag, row);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;

    // Clean press after reset: level 5 edges after first sample, then sel
    add(5,  0, 1, 0, 0, 0, 0, "t1_latency");
    add(1,  0, 1, 0, 1, 1, 0, "t1_rise");
    add(1,  0, 1, 0, 1, 0, 1, "t1_sel");
    add(13, 0, 1, 0, 1, 0, 1, "t1_hold");
    // Release: level falls after 5 edges, no pulse, sel held
    add(5,  0, 0, 0, 1, 0, 1, "t2_rel_wait");
    add(1,  0, 0, 0, 0, 0, 1, "t2_fall");
    add(14, 0, 0, 0, 0, 0, 1, "t2_low");
    // Second clean press toggles sel back
    add(5,  0, 1, 0, 0, 0, 1, "t2_press_wait");
    add(1,  0, 1, 0, 1, 1, 1, "t2_rise");
    add(1,  0, 1, 0, 1, 0, 0, "t2_sel");
    add(13, 0, 1, 0, 1, 0, 0, "t2_hold");
    add(5,  0, 0, 0, 1, 0, 0, "t2_rel2_wait");
    add(15, 0, 0, 0, 0, 0, 0, "t2_low2");
    // Bounce: 3 high / 2 low, four times, never accepted
    for (int i = 0; i < 4; i++) begin
      add(3, 0, 1, 0, 0, 0, 0, "t3_bounce_hi");
      add(2, 0, 0, 0, 0, 0, 0, "t3_bounce_lo");
    end
    add(5,  0, 0, 0, 0, 0, 0, "t3_settle");
    // Auto-scan from reset: flips every 8 edges
    add(1,  1, 0, 0, 0, 0, 0, "t4_reset");
    add(8,  0, 0, 1, 0, 0, 0, "t4_first");
    add(8,  0, 0, 1, 0, 0, 1, "t4_flip1");
    add(8,  0, 0, 1, 0, 0, 0, "t4_flip2");
    add(5,  0, 0, 1, 0, 0, 1, "t4_flip3");
    // Disable at count 5: progress discarded, no toggles
    add(10, 0, 0, 0, 0, 0, 1, "t4_off");
    // Re-enable: first toggle a full period later
    add(8,  0, 0, 1, 0, 0, 1, "t4_reen");
    add(1,  0, 0, 1, 0, 0, 0, "t4_reen_flip");
    add(3,  0, 0, 0, 0, 0, 0, "t4_off2");
    // Collision: press lands on the auto wrap, sel flips once
    add(1,  1, 0, 0, 0, 0, 0, "t5_reset");
    add(2,  0, 0, 1, 0, 0, 0, "t5_pre");
    add(5,  0, 1, 1, 0, 0, 0, "t5_press_wait");
    add(1,  0, 1, 1, 1, 1, 0, "t5_rise_wrap");
    add(1,  0, 0, 1, 1, 0, 1, "t5_single_flip");
    add(4,  0, 0, 1, 1, 0, 1, "t5_rel_wait");
    add(1,  0, 0, 1, 0, 0, 1, "t5_fall");
    add(2,  0, 0, 1, 0, 0, 1, "t5_gap");
    add(1,  0, 0, 1, 0, 0, 0, "t5_auto_after");
    // Press mid-period restarts the auto counter
    add(5,  0, 1, 1, 0, 0, 0, "t5_press2_wait");
    add(1,  0, 1, 1, 1, 1, 0, "t5_rise2");
    add(1,  0, 1, 1, 1, 0, 1, "t5_btn_flip");
    add(7,  0, 1, 1, 1, 0, 1, "t5_no_early_auto");
    add(1,  0, 1, 1, 1, 0, 0, "t5_auto_restart");

    // Reset held with button high: outputs stay 0
    rst = 1'b1;
    bus.btn_in = 1'b1;
    bus.auto_en = 1'b0;
    #12;
    check(1'b0, 1'b0, 1'b0, "t1_reset_a", -1);
    #10;
    check(1'b0, 1'b0, 1'b0, "t1_reset_b", -1);
    #3;  // release at 25 ns via the first table row

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].btn, vecs[i].auto_en,
           vecs[i].exp_level, vecs[i].exp_pulse, vecs[i].exp_sel,
           vecs[i].tag, i);
    end

    // Reset mid-debounce (cnt=2) and mid-period (auto count 5)
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t6_reset", 0);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t6_auto", i);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "t6_auto_flip", 8);
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "t6_wait_high", 9 + i);
    #3;
    rst = 1'b1;
    #1;
    check(1'b0, 1'b0, 1'b0, "t6_async_clear", 13);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t6_rst_hold", 14);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t6_full_latency", 15 + i);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "t6_rise", 20);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "t6_sel", 21);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "t6_hold", 22);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
